// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin request issuer and its arbiter bench:
// default widths, the per-channel state encoding and grant-vector helpers.
package rr_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int IDX_W_DEF   = 2;
    localparam int CNT_W_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } ch_state_e;

    // Binary index of the lowest set bit; 0 for an all-zero vector.
    function automatic logic [IDX_W_DEF-1:0] onehot_to_idx(input logic [NUM_REQ_DEF-1:0] vec);
        logic [IDX_W_DEF-1:0] idx;
        idx = '0;
        for (int i = NUM_REQ_DEF - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W_DEF'(i);
        end
        return idx;
    endfunction

    // True when at most one bit is set.
    function automatic logic is_onehot0(input logic [NUM_REQ_DEF-1:0] vec);
        return (vec & (vec - 1'b1)) == '0;
    endfunction

endpackage

// File: rtl/rr_req_channel.sv
// One requester channel: pending-transaction counter, IDLE/REQ/RELEASE FSM
// and the registered request bit presented to the arbiter.
module rr_req_channel
    import rr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_push,
    input  logic i_enable,
    input  logic i_grant,      // grant bit, already cleared when the grant is illegal
    output logic o_request,
    output logic o_idle,
    output logic o_service,
    output logic o_full,
    output logic o_drop
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ch_state_e        r_state;
    ch_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_request;
    logic             w_accept;
    logic             w_service;

    // Pending count: push adds, service removes, a push at max only lands if a service frees a slot
    always_comb begin
        w_accept    = i_push && ((r_count != CNT_MAX) || w_service);
        w_count_nxt = r_count;
        if (w_accept && !w_service) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_accept && w_service) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // State register; the request bit is registered from the next state so it is glitch-free
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_request <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_request <= (w_state_nxt == REQ);
        end
    end

    // Next state: enable low parks the channel; RELEASE holds the request low for one cycle
    always_comb begin
        w_state_nxt = r_state;
        if (!i_enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_count_nxt != '0) w_state_nxt = REQ;
                REQ:     if (w_service) w_state_nxt = RELEASE;
                RELEASE: w_state_nxt = (w_count_nxt != '0) ? REQ : IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Outputs: a grant only counts while requesting and running; grants in RELEASE are stale
    always_comb begin
        w_service = (r_state == REQ) && i_grant && i_enable;
        o_service = w_service;
        o_idle    = (r_state == IDLE);
        o_request = r_request;
        o_full    = (r_count == CNT_MAX);
        o_drop    = i_push && !w_accept;
    end

endmodule

// File: rtl/rr_request_issuer.sv
// Requester-side companion of the 4-way round-robin arbiter: drives its
// request/enable inputs, checks every grant and reports serviced channels.
module rr_request_issuer
    import rr_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_push,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_incoming_requests,
    output logic               o_arb_enable,
    input  logic [NUM_REQ-1:0] i_grant_vector,
    input  logic [IDX_W-1:0]   i_index,
    output logic [NUM_REQ-1:0] o_serviced,
    output logic [IDX_W-1:0]   o_serviced_idx,
    output logic [NUM_REQ-1:0] o_pend_full,
    output logic               o_drop_err,
    output logic               o_grant_err
);

    logic [NUM_REQ-1:0] w_idle;
    logic [NUM_REQ-1:0] w_service;
    logic [NUM_REQ-1:0] w_drop;
    logic [NUM_REQ-1:0] w_grant_ok;
    logic               w_illegal;

    logic               r_arb_enable;
    logic [NUM_REQ-1:0] r_serviced;
    logic [IDX_W-1:0]   r_serviced_idx;
    logic               r_drop_err;
    logic               r_grant_err;

    // Grant legality: at most one bit, never to an idle channel, index must match the vector.
    // An illegal grant is masked off entirely so it can never count as a service.
    always_comb begin
        w_illegal = !is_onehot0(i_grant_vector)
                 || ((i_grant_vector & w_idle) != '0)
                 || ((i_grant_vector != '0) && (i_index != onehot_to_idx(i_grant_vector)));
        w_grant_ok = w_illegal ? '0 : i_grant_vector;
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ch
        rr_req_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_push    (i_push[g]),
            .i_enable  (i_enable),
            .i_grant   (w_grant_ok[g]),
            .o_request (o_incoming_requests[g]),
            .o_idle    (w_idle[g]),
            .o_service (w_service[g]),
            .o_full    (o_pend_full[g]),
            .o_drop    (w_drop[g])
        );
    end

    // Service pulses, held last index, arbiter enable and sticky error flags
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_arb_enable   <= 1'b0;
            r_serviced     <= '0;
            r_serviced_idx <= '0;
            r_drop_err     <= 1'b0;
            r_grant_err    <= 1'b0;
        end else begin
            r_arb_enable <= i_enable;
            r_serviced   <= w_service;
            if (w_service != '0) begin
                r_serviced_idx <= onehot_to_idx(w_service);
            end
            if (w_drop != '0) begin
                r_drop_err <= 1'b1;
            end
            if (r_arb_enable && w_illegal) begin
                r_grant_err <= 1'b1;
            end
        end
    end

    assign o_arb_enable   = r_arb_enable;
    assign o_serviced     = r_serviced;
    assign o_serviced_idx = r_serviced_idx;
    assign o_drop_err     = r_drop_err;
    assign o_grant_err    = r_grant_err;

endmodule
